// File: rtl/axi_req_flit_packer_pkg.sv
// Shared definitions for the HMC request FLIT packer: FLIT type and TUSER flag layout.
package axi_req_pkg;

  localparam int FLIT_W         = 128;
  localparam int TUSER_PER_FLIT = 16;

  typedef logic [FLIT_W-1:0] flit_t;

  // TUSER is split into per-slot flag groups, each FPW bits wide.
  typedef enum logic [1:0] {
    TU_VALID = 2'd0,
    TU_HDR   = 2'd1,
    TU_TAIL  = 2'd2
  } tuser_field_e;

  // Bit offset of a flag group inside TUSER for a given FLITs-per-word.
  function automatic int tuser_base(input tuser_field_e field, input int fpw);
    return int'(field) * fpw;
  endfunction

endpackage

// File: rtl/axi_req_flit_packer_if.sv
// FLIT input handshake plus AXI-stream request beat towards the HMC controller.
interface axi_req_flit_packer_if #(
  parameter int FPW = 2
) ();
  import axi_req_pkg::*;

  logic                        flit_valid;
  logic                        flit_ready;
  flit_t                       flit_data;
  logic                        flit_sop;
  logic                        flit_eop;

  logic                        TVALID;
  logic                        TREADY;
  logic [FPW*FLIT_W-1:0]       TDATA;
  logic [FPW*TUSER_PER_FLIT-1:0] TUSER;

  // Packer side: sinks FLITs, sources beats.
  modport master (
    input  flit_valid, flit_data, flit_sop, flit_eop, TREADY,
    output flit_ready, TVALID, TDATA, TUSER
  );

  // Request generator / controller side.
  modport slave (
    output flit_valid, flit_data, flit_sop, flit_eop, TREADY,
    input  flit_ready, TVALID, TDATA, TUSER
  );

endinterface

// File: rtl/axi_req_flit_packer_out_stage.sv
// Output register of the packer: owns TVALID/TDATA/TUSER and the TREADY handshake.
module axi_req_out_stage #(
  parameter int DATA_W = 256,
  parameter int USER_W = 32
) (
  input  logic              clk,
  input  logic              res_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic [USER_W-1:0] i_user,
  input  logic              i_tready,
  output logic              o_out_free,
  output logic              o_tvalid,
  output logic [DATA_W-1:0] o_tdata,
  output logic [USER_W-1:0] o_tuser
);

  logic              r_tvalid;
  logic [DATA_W-1:0] r_tdata;
  logic [USER_W-1:0] r_tuser;

  // The register can take a new beat when empty or when its current beat leaves this edge.
  assign o_out_free = !r_tvalid || i_tready;
  assign o_tvalid   = r_tvalid;
  assign o_tdata    = r_tdata;
  assign o_tuser    = r_tuser;

  // Load a new beat, otherwise retire the current one on handshake; data is untouched while stalled.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_tvalid <= 1'b0;
      r_tdata  <= '0;
      r_tuser  <= '0;
    end else if (i_load) begin
      r_tvalid <= 1'b1;
      r_tdata  <= i_data;
      r_tuser  <= i_user;
    end else if (i_tready) begin
      r_tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/axi_req_flit_packer.sv
// Packs single request FLITs into FPW-wide AXI-stream beats with per-slot Valid/Hdr/Tail flags.
module axi_req_flit_packer
  import axi_req_pkg::*;
#(
  parameter int FPW   = 2,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  res_n,
  axi_req_flit_packer_if.master bus,
  output logic                  proto_err,
  output logic [CNT_W-1:0]      pkt_cnt
);

  localparam int DATA_W  = FPW * FLIT_W;
  localparam int USER_W  = FPW * TUSER_PER_FLIT;
  localparam int PTR_W   = (FPW > 1) ? $clog2(FPW) : 1;
  localparam int VALID_B = tuser_base(TU_VALID, FPW);
  localparam int HDR_B   = tuser_base(TU_HDR, FPW);
  localparam int TAIL_B  = tuser_base(TU_TAIL, FPW);
  localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(FPW - 1);

  logic [DATA_W-1:0] r_asm_data;
  logic [FPW-1:0]    r_asm_vld;
  logic [FPW-1:0]    r_asm_hdr;
  logic [FPW-1:0]    r_asm_tail;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic              r_held;
  logic              r_in_pkt;
  logic              r_proto_err;
  logic [CNT_W-1:0]  r_pkt_cnt;

  logic [DATA_W-1:0] w_ins_data;
  logic [FPW-1:0]    w_ins_vld;
  logic [FPW-1:0]    w_ins_hdr;
  logic [FPW-1:0]    w_ins_tail;
  logic [USER_W-1:0] w_ins_user;
  logic              w_accept;
  logic              w_close;
  logic              w_load;
  logic              w_out_free;
  logic              w_seq_err;

  // A closing accept is allowed even under backpressure: the full word simply parks in HELD,
  // so input is only stalled while a closed word is waiting for the output register.
  assign bus.flit_ready = !r_held;
  assign w_accept       = bus.flit_valid && !r_held;

  // Close on filling the last slot, or on any cycle without an accept while words are pending
  // (this also keeps a HELD word closed until it can move).
  assign w_close = (w_accept && (r_wr_ptr == LAST_SLOT)) || (!w_accept && r_asm_vld[0]);
  assign w_load  = w_close && w_out_free;

  // Header must open a packet and may not appear inside one.
  assign w_seq_err = (bus.flit_sop && r_in_pkt) || (!bus.flit_sop && !r_in_pkt);

  assign proto_err = r_proto_err;
  assign pkt_cnt   = r_pkt_cnt;

  // Assembly contents including this cycle's FLIT, so a closing word carries it straight out.
  always_comb begin
    w_ins_data = r_asm_data;
    w_ins_vld  = r_asm_vld;
    w_ins_hdr  = r_asm_hdr;
    w_ins_tail = r_asm_tail;
    if (w_accept) begin
      for (int i = 0; i < FPW; i++) begin
        if (r_wr_ptr == PTR_W'(i)) begin
          w_ins_data[i*FLIT_W +: FLIT_W] = bus.flit_data;
          w_ins_vld[i]                   = 1'b1;
          w_ins_hdr[i]                   = bus.flit_sop;
          w_ins_tail[i]                  = bus.flit_eop;
        end
      end
    end
  end

  // TUSER image of the assembled word; flag groups beyond Tail stay zero.
  always_comb begin
    w_ins_user                   = '0;
    w_ins_user[VALID_B +: FPW]   = w_ins_vld;
    w_ins_user[HDR_B +: FPW]     = w_ins_hdr;
    w_ins_user[TAIL_B +: FPW]    = w_ins_tail;
  end

  // Assembly register: clear on hand-off, park on blocked close, otherwise fill slot by slot.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_asm_data <= '0;
      r_asm_vld  <= '0;
      r_asm_hdr  <= '0;
      r_asm_tail <= '0;
      r_wr_ptr   <= '0;
      r_held     <= 1'b0;
    end else if (w_load) begin
      r_asm_data <= '0;
      r_asm_vld  <= '0;
      r_asm_hdr  <= '0;
      r_asm_tail <= '0;
      r_wr_ptr   <= '0;
      r_held     <= 1'b0;
    end else if (w_close) begin
      r_asm_data <= w_ins_data;
      r_asm_vld  <= w_ins_vld;
      r_asm_hdr  <= w_ins_hdr;
      r_asm_tail <= w_ins_tail;
      r_held     <= 1'b1;
    end else if (w_accept) begin
      r_asm_data <= w_ins_data;
      r_asm_vld  <= w_ins_vld;
      r_asm_hdr  <= w_ins_hdr;
      r_asm_tail <= w_ins_tail;
      r_wr_ptr   <= r_wr_ptr + 1'b1;
    end
  end

  // Packet framing tracker, sticky sequencing error and tail counter.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_in_pkt    <= 1'b0;
      r_proto_err <= 1'b0;
      r_pkt_cnt   <= '0;
    end else if (w_accept) begin
      r_in_pkt <= (r_in_pkt || bus.flit_sop) && !bus.flit_eop;
      if (w_seq_err) begin
        r_proto_err <= 1'b1;
      end
      if (bus.flit_eop) begin
        r_pkt_cnt <= r_pkt_cnt + 1'b1;
      end
    end
  end

  axi_req_out_stage #(
    .DATA_W (DATA_W),
    .USER_W (USER_W)
  ) u_out_stage (
    .clk        (clk),
    .res_n      (res_n),
    .i_load     (w_load),
    .i_data     (w_ins_data),
    .i_user     (w_ins_user),
    .i_tready   (bus.TREADY),
    .o_out_free (w_out_free),
    .o_tvalid   (bus.TVALID),
    .o_tdata    (bus.TDATA),
    .o_tuser    (bus.TUSER)
  );

endmodule
